// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes (execute and fetch-only), status flag bit positions, datapath width.
// No logic of its own; the helper below classifies which opcodes update the flags.
package cpu_pkg;
  localparam int DATA_W = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BN   = 4'hA;
  localparam logic [3:0] OP_SH   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_INC  = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_Z = 5;
  localparam int FLAG_C = 0;

  function automatic logic writes_flags(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_MOV) || op == OP_SH || op == OP_CMP || op == OP_INC;
  endfunction
endpackage

// File: rtl/exec_unit_if.sv
// Fetch <-> execute bundle: decoded instruction fields in, status/output port/debug read out.
// Fetch drives the master side; exec_unit consumes the slave side.
interface exec_unit_if;
  import cpu_pkg::*;

  logic [3:0]        opcode;
  logic [3:0]        reg1;
  logic [3:0]        reg2;
  logic [3:0]        reg3;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] sreg1;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output opcode, reg1, reg2, reg3, dbg_addr,
    input  sreg1, out_data, out_valid, dbg_data
  );

  modport slave (
    input  opcode, reg1, reg2, reg3, dbg_addr,
    output sreg1, out_data, out_valid, dbg_data
  );
endinterface

// File: rtl/regfile16x8.sv
// General register file: two combinational read ports plus debug read, one synchronous write port.
// Latency: reads 0 cycles, write visible after the committing edge. Backpressure: none.
// r0 is never written and always reads as zero.
module regfile16x8 #(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  ra_data,
  output logic [W-1:0]  rb_data,
  output logic [W-1:0]  dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);
  logic [W-1:0] mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/exec_unit.sv
// Execute stage: register file, single-cycle ALU, flag register, output port.
// Latency: commits at the edge after fetch presents the instruction. Backpressure: none, one op per cycle.
// sreg1 forwards the current op's flags so fetch can branch on the immediately preceding instruction.
import cpu_pkg::*;

module exec_unit #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  exec_unit_if.slave bus
);
  logic [DATA_W-1:0] a, b, opb, res;
  logic [DATA_W-1:0] flags_q, flags_d, out_q;
  logic [DATA_W:0]   sum, sh;
  logic [2:0]        amt;
  logic              c_n, v_n, we, fw, out_vld_q;

  regfile16x8 #(.W(DATA_W), .N(NREGS), .AW(4)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (bus.reg2),
    .rb_addr  (bus.reg3),
    .dbg_addr (bus.dbg_addr),
    .ra_data  (a),
    .rb_data  (b),
    .dbg_data (bus.dbg_data),
    .we       (we),
    .wr_addr  (bus.reg1),
    .wr_data  (res)
  );

  assign fw = writes_flags(bus.opcode);

  always_comb begin
    res = '0;
    we  = 1'b0;
    c_n = flags_q[FLAG_C];
    v_n = flags_q[FLAG_V];
    sum = '0;
    sh  = '0;
    amt = bus.reg3[2:0];
    opb = (bus.opcode == OP_INC) ? DATA_W'(1) : b;
    case (bus.opcode)
      OP_ADD, OP_INC: begin
        sum = {1'b0, a} + {1'b0, opb};
        res = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
        v_n = (a[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        we  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // bit 8 of the 9-bit difference is the borrow
        sum = {1'b0, a} - {1'b0, b};
        res = sum[DATA_W-1:0];
        c_n = sum[DATA_W];
        v_n = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        we  = (bus.opcode == OP_SUB);
      end
      OP_AND: begin res = a & b; c_n = 1'b0; v_n = 1'b0; we = 1'b1; end
      OP_OR:  begin res = a | b; c_n = 1'b0; v_n = 1'b0; we = 1'b1; end
      OP_XOR: begin res = a ^ b; c_n = 1'b0; v_n = 1'b0; we = 1'b1; end
      OP_LDI: begin res = {bus.reg2, bus.reg3}; we = 1'b1; end
      OP_MOV: begin res = a; we = 1'b1; end
      OP_SH: begin
        v_n = 1'b0;
        we  = 1'b1;
        if (bus.reg3[3]) begin
          sh  = {a, 1'b0} >> amt;
          res = sh[DATA_W:1];
          if (amt != 3'd0) c_n = sh[0];
        end else begin
          sh  = {1'b0, a} << amt;
          res = sh[DATA_W-1:0];
          if (amt != 3'd0) c_n = sh[DATA_W];
        end
      end
      default: ;
    endcase
    flags_d         = '0;
    flags_d[FLAG_N] = res[DATA_W-1];
    flags_d[FLAG_V] = v_n;
    flags_d[FLAG_Z] = (res == '0);
    flags_d[FLAG_C] = c_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (fw) flags_q <= flags_d;
      out_vld_q <= (bus.opcode == OP_OUT);
      if (bus.opcode == OP_OUT) out_q <= a;
    end
  end

  // masked in reset so an undriven opcode cannot leak onto the branch flags
  assign bus.sreg1     = rst ? '0 : (fw ? flags_d : flags_q);
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_vld_q;
endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed vector table, hand-written corner sequences, random ops vs an arithmetic model.
module tb_exec_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_unit_if bus ();

  exec_unit #(.DATA_W(8), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int mr [16];
  int fn, fv, fz, fc, od, ov;
  int p_res, p_a, p_we, p_fw, p_n, p_v, p_z, p_c;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, want %02h", name, act, exp);
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic logic [7:0] pack(input int n, input int v, input int z, input int c);
    return 8'((n << 7) | (v << 6) | (z << 5) | c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 0;
    fn = 0; fv = 0; fz = 0; fc = 0; od = 0; ov = 0;
  endtask

  task automatic model_eval(input logic [3:0] op, input logic [3:0] s, input logic [3:0] t);
    int a, b, full, sr, amt;
    a = mr[s];
    b = mr[t];
    p_a = a; p_res = 0; p_we = 0; p_fw = 1; p_c = fc; p_v = fv;
    case (op)
      OP_ADD, OP_INC: begin
        if (op == OP_INC) b = 1;
        full = a + b; p_res = full % 256; p_c = (full > 255);
        sr = sgn(a) + sgn(b); p_v = (sr > 127 || sr < -128); p_we = 1;
      end
      OP_SUB, OP_CMP: begin
        full = a - b; p_res = (full + 256) % 256; p_c = (a < b);
        sr = sgn(a) - sgn(b); p_v = (sr > 127 || sr < -128); p_we = (op == OP_SUB);
      end
      OP_AND: begin p_res = a & b; p_c = 0; p_v = 0; p_we = 1; end
      OP_OR:  begin p_res = a | b; p_c = 0; p_v = 0; p_we = 1; end
      OP_XOR: begin p_res = a ^ b; p_c = 0; p_v = 0; p_we = 1; end
      OP_LDI: begin p_res = s * 16 + t; p_we = 1; end
      OP_MOV: begin p_res = a; p_we = 1; end
      OP_SH: begin
        amt = t % 8; p_v = 0; p_we = 1;
        if (t >= 8) begin
          p_res = a / (1 << amt);
          if (amt > 0) p_c = (a / (1 << (amt - 1))) % 2;
        end else begin
          full = a * (1 << amt);
          p_res = full % 256;
          if (amt > 0) p_c = (full / 256) % 2;
        end
      end
      default: p_fw = 0;
    endcase
    p_n = (p_res >= 128);
    p_z = (p_res == 0);
  endtask

  task automatic model_commit(input logic [3:0] op, input logic [3:0] d);
    if (p_we != 0 && d != 0) mr[d] = p_res;
    if (p_fw != 0) begin fn = p_n; fv = p_v; fz = p_z; fc = p_c; end
    ov = (op == OP_OUT);
    if (op == OP_OUT) od = p_a;
  endtask

  // presents one instruction for a full cycle; returns sreg1 as seen before the commit edge
  task automatic exec(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s,
                      input logic [3:0] t, output logic [7:0] fwd);
    @(negedge clk);
    bus.opcode = op; bus.reg1 = d; bus.reg2 = s; bus.reg3 = t; bus.dbg_addr = d;
    model_eval(op, s, t);
    #1;
    fwd = bus.sreg1;
    check("sreg_fwd", fwd, (p_fw != 0) ? pack(p_n, p_v, p_z, p_c) : pack(fn, fv, fz, fc));
    @(posedge clk);
    #1;
    model_commit(op, d);
    check("regfile", bus.dbg_data, 8'(mr[d]));
    check("out_valid", {7'd0, bus.out_valid}, 8'(ov));
    check("out_data", bus.out_data, 8'(od));
  endtask

  typedef struct {
    logic [3:0] op, d, s, t;
    logic [7:0] sreg, rd;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  logic [7:0] fwd;
  logic [3:0] rop, rd_, rs, rt;

  initial begin
    vec[0]  = '{OP_LDI,  4'd1,  4'h7, 4'hF, 8'h00, 8'h7F};
    vec[1]  = '{OP_LDI,  4'd2,  4'h0, 4'h1, 8'h00, 8'h01};
    vec[2]  = '{OP_ADD,  4'd3,  4'd1, 4'd2, 8'hC0, 8'h80};
    vec[3]  = '{OP_LDI,  4'd1,  4'h0, 4'h5, 8'h40, 8'h05};
    vec[4]  = '{OP_SUB,  4'd2,  4'd1, 4'd1, 8'h20, 8'h00};
    vec[5]  = '{OP_LDI,  4'd2,  4'h0, 4'h6, 8'h00, 8'h06};
    vec[6]  = '{OP_CMP,  4'd1,  4'd1, 4'd2, 8'h81, 8'h05};
    vec[7]  = '{OP_LDI,  4'd4,  4'h8, 4'h1, 8'h81, 8'h81};
    vec[8]  = '{OP_SH,   4'd5,  4'd4, 4'h1, 8'h01, 8'h02};
    vec[9]  = '{OP_SH,   4'd5,  4'd4, 4'h9, 8'h01, 8'h40};
    vec[10] = '{OP_ADD,  4'd0,  4'd3, 4'd0, 8'h80, 8'h00};
    vec[11] = '{OP_LDI,  4'd3,  4'hA, 4'h5, 8'h80, 8'hA5};
    vec[12] = '{OP_OUT,  4'd3,  4'd3, 4'd0, 8'h80, 8'hA5};
    vec[13] = '{OP_JMP,  4'd3,  4'd0, 4'd0, 8'h80, 8'hA5};
    vec[14] = '{OP_INC,  4'd6,  4'd3, 4'd0, 8'h80, 8'hA6};
    vec[15] = '{OP_XOR,  4'd7,  4'd6, 4'd6, 8'h20, 8'h00};
    vec[16] = '{OP_OR,   4'd7,  4'd4, 4'd5, 8'h80, 8'hC1};
    vec[17] = '{OP_AND,  4'd8,  4'd7, 4'd4, 8'h80, 8'h81};
    vec[18] = '{OP_MOV,  4'd9,  4'd7, 4'd0, 8'h80, 8'hC1};
    vec[19] = '{OP_LDI,  4'd10, 4'hF, 4'hF, 8'h80, 8'hFF};
    vec[20] = '{OP_INC,  4'd11, 4'd10, 4'd0, 8'h21, 8'h00};
    vec[21] = '{OP_HALT, 4'd11, 4'd10, 4'd0, 8'h21, 8'h00};

    bus.opcode = OP_NOP; bus.reg1 = '0; bus.reg2 = '0; bus.reg3 = '0; bus.dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_sreg1", bus.sreg1, 8'h00);
    check("reset_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("reset_out_data", bus.out_data, 8'h00);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      check("reset_reg", bus.dbg_data, 8'h00);
    end

    for (int i = 0; i < NV; i++) begin
      exec(vec[i].op, vec[i].d, vec[i].s, vec[i].t, fwd);
      check("tbl_sreg", fwd, vec[i].sreg);
      check("tbl_rd", bus.dbg_data, vec[i].rd);
    end

    // OUT pulse, back-to-back OUTs, then drop
    exec(OP_OUT, 4'd0, 4'd3, 4'd0, fwd);
    check("out1_valid", {7'd0, bus.out_valid}, 8'h01);
    check("out1_data", bus.out_data, 8'hA5);
    exec(OP_OUT, 4'd0, 4'd6, 4'd0, fwd);
    check("out2_valid", {7'd0, bus.out_valid}, 8'h01);
    check("out2_data", bus.out_data, 8'hA6);
    exec(OP_NOP, 4'd0, 4'd0, 4'd0, fwd);
    check("out_drop_valid", {7'd0, bus.out_valid}, 8'h00);
    check("out_hold_data", bus.out_data, 8'hA6);

    // zero-result SUB must expose Z before its commit edge; BZ then changes nothing
    exec(OP_SUB, 4'd2, 4'd1, 4'd1, fwd);
    check("bz_fwd_z", {7'd0, fwd[5]}, 8'h01);
    exec(OP_BZ, 4'd2, 4'd4, 4'd4, fwd);
    check("bz_sreg", bus.sreg1, 8'h20);
    check("bz_r2", bus.dbg_data, 8'h00);

    for (int i = 0; i < 3; i++) exec(OP_HALT, 4'd4, 4'd1, 4'd2, fwd);
    check("halt_r4", bus.dbg_data, 8'h81);
    check("halt_sreg", bus.sreg1, 8'h20);

    // asynchronous reset between edges during an ADD
    @(negedge clk);
    bus.opcode = OP_ADD; bus.reg1 = 4'd12; bus.reg2 = 4'd4; bus.reg3 = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    check("arst_sreg1", bus.sreg1, 8'h00);
    check("arst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("arst_out_data", bus.out_data, 8'h00);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #0.1;
      check("arst_reg", bus.dbg_data, 8'h00);
    end
    @(negedge clk);
    bus.opcode = 4'($urandom); bus.reg1 = 4'($urandom);
    @(negedge clk);
    bus.opcode = OP_NOP;
    rst = 1'b0;
    model_reset();
    bus.dbg_addr = 4'd12;
    #1;
    check("arst_no_commit", bus.dbg_data, 8'h00);
    exec(OP_LDI, 4'd12, 4'h3, 4'hC, fwd);
    check("first_commit", bus.dbg_data, 8'h3C);

    for (int i = 0; i < 400; i++) begin
      rop = 4'($urandom_range(0, 15));
      rd_ = 4'($urandom_range(0, 15));
      rs  = 4'($urandom_range(0, 15));
      rt  = 4'($urandom_range(0, 15));
      exec(rop, rd_, rs, rt, fwd);
    end
    exec(OP_NOP, 4'd0, 4'd0, 4'd0, fwd);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      check("final_reg", bus.dbg_data, 8'(mr[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the 8-bit CPU, directly downstream of the instruction fetch/memory stage. Consumes the registered decoded fields `opcode`, `reg1`, `reg2` and `reg3` every cycle. Holds the 16×8 general register file, runs one ALU operation per cycle and writes the result back. Produces the status register `sreg1` that fetch samples for BZ/BN, plus a simple output port.

## Interface
- `DATA_W`, default 8: datapath width. Only 8 is supported.
- `NREGS`, default 16: register count; addressed by a 4-bit field.

Ports:
- `clk`  in  1: system clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `opcode`  in  4: instruction opcode from fetch.
- `reg1`  in  4: destination register `rd`.
- `reg2`  in  4: source `ra`, or immediate high nibble.
- `reg3`  in  4: source `rb`, immediate low nibble, or shift control.
- `sreg1`  out  8: status flags. Bit 7 N, bit 6 V, bit 5 Z, bit 0 C; all other bits 0.
- `out_data`  out  8: last value written by OUT.
- `out_valid`  out  1: one-cycle pulse on each OUT.
- `dbg_addr`  in  4: register-file debug read address.
- `dbg_data`  out  8: combinational read of `r[dbg_addr]`.

## Operation
- Opcode map:
  - 0000 NOP.
  - 0001 ADD: rd=ra+rb.
  - 0010 SUB: rd=ra−rb.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 LDI: rd={reg2,reg3}.
  - 0111 MOV: rd=ra.
  - 1011 SH: shift rd=ra. `reg3[3]`=1 right (logical), 0 left; `reg3[2:0]` is the amount.
  - 1101 CMP: flags of ra−rb, no writeback.
  - 1110 INC: rd=ra+1.
  - 1111 OUT: `out_data`←ra, `out_valid`=1.
- 1000 JMP, 1001 BZ, 1010 BN and 1100 HALT are fetch-only. They cause no writeback and no flag change.
- `r0` reads as 0. Writes to `r0` are discarded; flags still update.
- Arithmetic is modulo 256.
  - ADD/INC: C = carry out of bit 7.
  - SUB/CMP: C = borrow (ra < rb, unsigned).
  - V = signed overflow of the 8-bit operation.
- Logic ops (AND/OR/XOR): clear C and V.
- MOV/LDI: leave C and V unchanged.
- SH: C = last bit shifted out. With amount 0, C is unchanged. V is cleared.
- N = result[7] and Z = (result == 0) for every flag-writing op, including writes targeting `r0`. "Result" is the computed value, not the `r0` readback.
- Flag-writing ops: all of 0001–0111, 1011, 1101, 1110. OUT does not touch flags.

## Timing
- Fetch latches an instruction at edge k. `exec_unit` decodes it combinationally during cycle k→k+1 and commits the writeback, stored flags and `out_data`/`out_valid` at edge k+1.
- Register reads happen after the previous instruction's writeback. There is no intra-stage hazard.
- `sreg1` is forwarded:
  - When the instruction currently present is flag-writing, `sreg1` shows its next-state flags combinationally.
  - Otherwise it shows the stored flags.
  - This lets fetch, which evaluates the following branch at edge k+1, branch on the immediately preceding instruction.
- `out_valid` is high for exactly the one cycle after the edge that commits an OUT. Back-to-back OUTs hold it high continuously with updated `out_data`.
- HALT held by fetch: opcode remains 1100, so no state changes. Outputs stay stable.
- Reset (asynchronous, mid-instruction included):
  - All registers, stored flags, `out_data` and `out_valid` go to 0 immediately.
  - The instruction in flight is not committed.
  - The first commit happens at the first rising edge after `rst` deasserts.
- The inputs from fetch have no reset. An X opcode must not corrupt state while `rst` is high.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (including fetch's JMP/BZ/BN/HALT);
  - flag bit indices `FLAG_N=7`, `FLAG_V=6`, `FLAG_Z=5`, `FLAG_C=0`;
  - `DATA_W`.
- Sub-module `regfile16x8`:
  - two combinational read ports (ra, rb) plus the debug read port;
  - one synchronous write port;
  - asynchronous reset to zero;
  - `r0` hardwired to zero.
- The ALU and flag logic stay in `exec_unit` as a combinational block feeding the registered state.

## Test plan
- LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2 → r3=0x80, `sreg1`=0xC0 (N=1, V=1, Z=0, C=0).
- LDI r1,0x05; SUB r2,r1,r1 → r2=0x00, Z=1, C=0. Then CMP r1,r2 with r2=0x06 → flags N=1, C=1, no register change.
- LDI r4,0x81; SH r5,r4 with reg3=0x1 (left 1) → r5=0x02, C=1. SH right with reg3=0x9 → r5=0x40, C=1.
- ADD r0,r1,r2 with result 0x80 → `dbg_data`(r0)=0x00 and N=1. OUT r3 with r3=0xA5 → `out_data`=0xA5, `out_valid` high exactly one cycle.
- SUB giving zero followed by opcode 1001 in the same cycle window → `sreg1[5]`=1 is visible combinationally before the commit edge, so fetch takes BZ.
- Assert `rst` between edges during an ADD → all registers, `sreg1`, `out_valid` read 0 immediately; the ADD never commits.
